// File: rtl/reflector_ukw_b.sv
// Fixed Enigma UKW-B reflector: one registered letter per clock, with an error
// flag for indices outside A..Z.
module reflector_ukw_b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] char_in,
    output logic [4:0] char_out,
    output logic       char_err
);

    logic [4:0] char_out_d;
    logic [4:0] char_out_q;
    logic       char_err_d;
    logic       char_err_q;

    // Each pair appears twice so the table reads directly as an involution.
    always_comb begin
        char_out_d = 5'd31;
        char_err_d = 1'b0;
        case (char_in)
            5'd0:  char_out_d = 5'd24;
            5'd1:  char_out_d = 5'd17;
            5'd2:  char_out_d = 5'd20;
            5'd3:  char_out_d = 5'd7;
            5'd4:  char_out_d = 5'd16;
            5'd5:  char_out_d = 5'd18;
            5'd6:  char_out_d = 5'd11;
            5'd7:  char_out_d = 5'd3;
            5'd8:  char_out_d = 5'd15;
            5'd9:  char_out_d = 5'd23;
            5'd10: char_out_d = 5'd13;
            5'd11: char_out_d = 5'd6;
            5'd12: char_out_d = 5'd14;
            5'd13: char_out_d = 5'd10;
            5'd14: char_out_d = 5'd12;
            5'd15: char_out_d = 5'd8;
            5'd16: char_out_d = 5'd4;
            5'd17: char_out_d = 5'd1;
            5'd18: char_out_d = 5'd5;
            5'd19: char_out_d = 5'd25;
            5'd20: char_out_d = 5'd2;
            5'd21: char_out_d = 5'd22;
            5'd22: char_out_d = 5'd21;
            5'd23: char_out_d = 5'd9;
            5'd24: char_out_d = 5'd0;
            5'd25: char_out_d = 5'd19;
            default: begin
                char_out_d = 5'd31;
                char_err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_out_q <= 5'd0;
            char_err_q <= 1'b0;
        end else begin
            char_out_q <= char_out_d;
            char_err_q <= char_err_d;
        end
    end

    assign char_out = char_out_q;
    assign char_err = char_err_q;

endmodule

// File: tb/tb_reflector_ukw_b.sv
// Self-checking bench for reflector_ukw_b; the expected mapping is built from
// the UKW-B pair list and expected outputs flow through a scoreboard queue.
module tb_reflector_ukw_b;

    logic       clk;
    logic       rst_n;
    logic [4:0] char_in;
    logic [4:0] char_out;
    logic       char_err;

    typedef struct packed {
        logic [4:0] ch;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    int         checks;
    int         errors;
    logic [4:0] ref_map [0:31];
    logic       ref_err [0:31];

    reflector_ukw_b dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .char_in  (char_in),
        .char_out (char_out),
        .char_err (char_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic build_model();
        int pa [13];
        int pb [13];
        pa = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 12, 19, 21};
        pb = '{24, 17, 20, 7, 16, 18, 11, 15, 23, 13, 14, 25, 22};
        for (int i = 0; i < 32; i++) begin
            ref_map[i] = 5'd31;
            ref_err[i] = 1'b1;
        end
        for (int i = 0; i < 13; i++) begin
            ref_map[pa[i]] = pb[i][4:0];
            ref_map[pb[i]] = pa[i][4:0];
            ref_err[pa[i]] = 1'b0;
            ref_err[pb[i]] = 1'b0;
        end
    endtask

    // Drive on the falling edge, record the expectation, compare just after
    // the next rising edge.
    task automatic drive(input logic [4:0] c);
        exp_t e;
        @(negedge clk);
        char_in = c;
        e.ch  = ref_map[c];
        e.err = ref_err[c];
        sb_q.push_back(e);
    endtask

    task automatic collect(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            if (char_out !== e.ch || char_err !== e.err) begin
                errors++;
                $display("FAIL %s char_in=%0d got out=%0d err=%b exp out=%0d err=%b",
                         name, char_in, char_out, char_err, e.ch, e.err);
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        char_in = 5'd30;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (char_out !== 5'd0 || char_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got out=%0d err=%b exp out=0 err=0", char_out, char_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'd0);
        collect("first_after_reset");
    endtask

    task automatic test_basic();
        drive(5'd1);  collect("b_to_r");
        drive(5'd25); collect("z_to_t");
        drive(5'd12); collect("m_to_o");
    endtask

    task automatic test_involution();
        logic [4:0] y;
        for (int x = 0; x < 26; x++) begin
            drive(x[4:0]);
            collect("sweep_fwd");
            y = char_out;
            checks++;
            if (y === x[4:0]) begin
                errors++;
                $display("FAIL self_map in=%0d got out=%0d exp out!=in", x, y);
            end
            drive(y);
            collect("sweep_back");
            checks++;
            if (char_out !== x[4:0] || char_err !== 1'b0) begin
                errors++;
                $display("FAIL involution in=%0d got out=%0d err=%b exp out=%0d err=0",
                         x, char_out, char_err, x);
            end
        end
    endtask

    task automatic test_invalid();
        drive(5'd30); collect("invalid_30");
        drive(5'd26); collect("invalid_26");
        drive(5'd31); collect("invalid_31");
        drive(5'd3);  collect("recover_d_to_h");
        drive(5'd27); collect("invalid_27");
        drive(5'd28); collect("invalid_28");
        drive(5'd29); collect("invalid_29");
    endtask

    task automatic test_mid_reset();
        drive(5'd21);
        collect("v_to_w");
        @(negedge clk);
        char_in = 5'd9;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (char_out !== 5'd0 || char_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got out=%0d err=%b exp out=0 err=0", char_out, char_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (char_out !== 5'd0 || char_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard got out=%0d err=%b exp out=0 err=0", char_out, char_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'd7);
        collect("release_h_to_d");
    endtask

    task automatic test_toggle();
        logic [4:0] prev;
        drive(5'd4);
        #2;
        char_in = 5'd9;
        sb_q.pop_back();
        sb_q.push_back({ref_map[9], ref_err[9]});
        prev = char_out;
        #1;
        checks++;
        if (char_out !== prev) begin
            errors++;
            $display("FAIL between_edges got out=%0d exp out=%0d", char_out, prev);
        end
        collect("toggle_last_value");
        #2;
        char_in = 5'd2;
        #1;
        checks++;
        if (char_out !== ref_map[9] || char_err !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_edge got out=%0d err=%b exp out=%0d err=0",
                     char_out, char_err, ref_map[9]);
        end
        sb_q.push_back({ref_map[2], ref_err[2]});
        collect("toggle_next_edge");
        drive(5'd30);
        #2;
        char_in = 5'd5;
        sb_q.pop_back();
        sb_q.push_back({ref_map[5], ref_err[5]});
        collect("toggle_invalid_to_valid");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive(5'($urandom_range(0, 31)));
            collect("random_stream");
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        char_in = 5'd0;
        build_model();
        test_reset();
        test_basic();
        test_involution();
        test_invalid();
        test_mid_reset();
        test_toggle();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left exp 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reflector_ukw_b.md
REFLECTOR_UKW_B -- requirements
Module: reflector_ukw_b

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: char_in  input  5  letter index, 0=A .. 25=Z; values 26..31 are invalid.
REQ-005 Port: char_out  output  5  registered reflected letter index.
REQ-006 Port: char_err  output  1  registered flag, 1 when the sampled char_in was invalid.
REQ-007 The block SHALL have no parameters; the wiring is fixed to Enigma UKW-B.

Function
REQ-008 On each rising clk edge with rst_n high, the block SHALL register the reflection of char_in into char_out, with exactly 1 cycle latency.
REQ-009 The reflection SHALL be the UKW-B involution, as numeric pairs (both directions): 0-24, 1-17, 2-20, 3-7, 4-16, 5-18, 6-11, 8-15, 9-23, 10-13, 12-14, 19-25, 21-22.
REQ-010 The same mapping by letter SHALL be: A-Y, B-R, C-U, D-H, E-Q, F-S, G-L, I-P, J-X, K-N, M-O, T-Z, V-W.
REQ-011 No valid input SHALL map to itself; for every valid x, reflect(reflect(x)) SHALL equal x.
REQ-012 For valid input, char_err SHALL be registered as 0 in the same edge as char_out.
REQ-013 For char_in in 26..31, char_out SHALL be registered as 5'd31 and char_err as 1.
REQ-014 The mapping SHALL be a pure function of the sampled char_in, with no history dependence.
REQ-015 char_in SHALL be sampled every cycle with no handshake; there is no enable or hold.
REQ-016 A change of char_in between edges SHALL NOT affect the outputs until the next rising edge.

Reset
REQ-017 While rst_n is low, char_out SHALL be 5'd0 and char_err SHALL be 0, asynchronously and regardless of clk.
REQ-018 When rst_n deasserts, the first rising edge with rst_n high SHALL load the reflection of the current char_in.
REQ-019 An assertion of rst_n mid-stream SHALL immediately force the reset values; a pending input is discarded.

Verification
REQ-020 Scenario: reset low -> char_out=0, char_err=0; release, then char_in=0 -> after 1 edge char_out=24 (A->Y), char_err=0.
REQ-021 Scenario: char_in=1 -> after 1 edge char_out=17 (B->R); char_in=25 -> char_out=19 (Z->T).
REQ-022 Scenario: sweep char_in 0..25; feed each registered char_out back as char_in -> the next char_out equals the original value, char_out never equals its own input, and char_err stays 0.
REQ-023 Scenario: char_in=30, and separately 26 and 31 -> after 1 edge char_out=31, char_err=1; then char_in=3 -> char_out=7, char_err=0.
REQ-024 Scenario: char_in=21 registered (char_out=22), then rst_n pulsed low between edges -> char_out=0 immediately, before any clk edge.
REQ-025 Scenario: char_in toggled between edges -> outputs change only at rising edges, and each output reflects the value present at that edge.
